parking_gate_controller: RTL and testbench

- Downstream of the parking FSM. Consumes its one-cycle door_open_pulse and drives the barrier-gate motor through a timed raise / hold / lower sequence.
- Holds the gate open while a vehicle is under it, and reopens if a vehicle or new request appears while closing.
- Counts vehicles that pass under the open gate.

---
 rtl/parking_gate_controller.sv | 127 ++++++++++++
 tb/tb_parking_gate_controller.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/parking_gate_controller.sv
// Barrier-gate motor sequencer: raise / dwell open / lower, with vehicle hold,
// reopen-on-demand while closing, and a count of vehicles passing the open gate.
module parking_gate_controller #(
  parameter int unsigned MOVE_TIME = 4,
  parameter int unsigned OPEN_TIME = 8,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             door_open_pulse,
  input  logic             car_sensor,
  output logic [1:0]       gate_state,
  output logic             gate_up,
  output logic             gate_down,
  output logic             gate_open,
  output logic             busy,
  output logic [CNT_W-1:0] pass_count
);

  localparam int unsigned TMR_W = 8;
  localparam logic [TMR_W-1:0] MOVE_RELOAD = TMR_W'(MOVE_TIME - 1);
  localparam logic [TMR_W-1:0] OPEN_RELOAD = TMR_W'(OPEN_TIME - 1);

  typedef enum logic [1:0] {
    ST_CLOSED  = 2'd0,
    ST_OPENING = 2'd1,
    ST_OPEN    = 2'd2,
    ST_CLOSING = 2'd3
  } gate_st_e;

  gate_st_e         state;
  logic [TMR_W-1:0] timer;
  logic             sensor_q;
  logic [3:0]       flags_q;   // {up, down, open, busy}

  // Motor/status flags belonging to a state; registered alongside the state.
  function automatic logic [3:0] flags_of(input gate_st_e s);
    logic [3:0] f;
    f = 4'b0000;
    case (s)
      ST_OPENING: f = 4'b1001;
      ST_OPEN:    f = 4'b0011;
      ST_CLOSING: f = 4'b0101;
      default:    f = 4'b0000;
    endcase
    return f;
  endfunction

  // Gate sequencer: state, dwell/move timer and registered output flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_CLOSED;
      timer   <= '0;
      flags_q <= 4'b0000;
    end else begin
      case (state)
        ST_CLOSED: begin
          if (door_open_pulse) begin
            state   <= ST_OPENING;
            timer   <= MOVE_RELOAD;
            flags_q <= flags_of(ST_OPENING);
          end
        end
        ST_OPENING: begin
          // Requests and the beam are irrelevant while the gate is rising.
          if (timer != '0) begin
            timer <= timer - TMR_W'(1);
          end else begin
            state   <= ST_OPEN;
            timer   <= OPEN_RELOAD;
            flags_q <= flags_of(ST_OPEN);
          end
        end
        ST_OPEN: begin
          if (car_sensor || door_open_pulse) begin
            timer <= OPEN_RELOAD;
          end else if (timer != '0) begin
            timer <= timer - TMR_W'(1);
          end else begin
            state   <= ST_CLOSING;
            timer   <= MOVE_RELOAD;
            flags_q <= flags_of(ST_CLOSING);
          end
        end
        ST_CLOSING: begin
          // A vehicle or new request always wins over finishing the descent.
          if (car_sensor || door_open_pulse) begin
            state   <= ST_OPENING;
            timer   <= MOVE_RELOAD;
            flags_q <= flags_of(ST_OPENING);
          end else if (timer != '0) begin
            timer <= timer - TMR_W'(1);
          end else begin
            state   <= ST_CLOSED;
            timer   <= '0;
            flags_q <= flags_of(ST_CLOSED);
          end
        end
        default: begin
          state   <= ST_CLOSED;
          timer   <= '0;
          flags_q <= 4'b0000;
        end
      endcase
    end
  end

  // Beam history and pass counter: count falling edges only while fully open.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sensor_q   <= 1'b0;
      pass_count <= '0;
    end else begin
      sensor_q <= car_sensor;
      if ((state == ST_OPEN) && sensor_q && !car_sensor) begin
        pass_count <= pass_count + CNT_W'(1);
      end
    end
  end

  assign gate_state = state;
  assign gate_up    = flags_q[3];
  assign gate_down  = flags_q[2];
  assign gate_open  = flags_q[1];
  assign busy       = flags_q[0];

endmodule

// File: tb/tb_parking_gate_controller.sv
// Directed, table-driven bench for parking_gate_controller at default parameters.
module tb_parking_gate_controller;

  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             door_open_pulse = 1'b0;
  logic             car_sensor = 1'b0;
  logic [1:0]       gate_state;
  logic             gate_up;
  logic             gate_down;
  logic             gate_open;
  logic             busy;
  logic [CNT_W-1:0] pass_count;

  int checks = 0;
  int failures = 0;

  parking_gate_controller #(
    .MOVE_TIME(4),
    .OPEN_TIME(8),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .door_open_pulse(door_open_pulse),
    .car_sensor(car_sensor),
    .gate_state(gate_state),
    .gate_up(gate_up),
    .gate_down(gate_down),
    .gate_open(gate_open),
    .busy(busy),
    .pass_count(pass_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       pulse;
    logic       sensor;
    logic [1:0] st;
    logic       up;
    logic       down;
    logic       opn;
    logic       bsy;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Apply inputs for one cycle, then sample 1 time unit after the edge.
  task automatic step(input logic p, input logic s);
    door_open_pulse = p;
    car_sensor      = s;
    @(posedge clk);
    #1;
  endtask

  // Count consecutive samples (including the current one) in state st.
  task automatic run_len(input string nm, input logic [1:0] st, input int exp_len);
    int n;
    n = 0;
    while (gate_state == st && n < 100) begin
      n++;
      step(1'b0, 1'b0);
    end
    chk(nm, n, exp_len);
  endtask

  task automatic run_table(input bit extra, input string tag);
    int   busy_n;
    logic p;
    busy_n = 0;
    for (int i = 0; i < 17; i++) begin
      p = tbl[i].pulse | (extra && i >= 1 && i <= 4);
      step(p, tbl[i].sensor);
      chk($sformatf("%s_state[%0d]", tag, i), int'(gate_state), int'(tbl[i].st));
      chk($sformatf("%s_up[%0d]", tag, i), int'(gate_up), int'(tbl[i].up));
      chk($sformatf("%s_down[%0d]", tag, i), int'(gate_down), int'(tbl[i].down));
      chk($sformatf("%s_open[%0d]", tag, i), int'(gate_open), int'(tbl[i].opn));
      chk($sformatf("%s_busy[%0d]", tag, i), int'(busy), int'(tbl[i].bsy));
      busy_n += int'(busy);
    end
    chk($sformatf("%s_busy_total", tag), busy_n, 16);
  endtask

  initial begin
    int open_n;
    int k;

    // Expected outputs after each edge of one uninterrupted cycle.
    tbl[0] = '{1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 1; i <= 3; i++)   tbl[i] = '{1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 4; i <= 11; i++)  tbl[i] = '{1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 12; i <= 15; i++) tbl[i] = '{1'b0, 1'b0, 2'd3, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[16] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset state
    #12;
    chk("rst_state", int'(gate_state), 0);
    chk("rst_up", int'(gate_up), 0);
    chk("rst_down", int'(gate_down), 0);
    chk("rst_open", int'(gate_open), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_count", int'(pass_count), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single request, then same with extra pulses on every OPENING cycle
    run_table(1'b0, "single");
    run_table(1'b1, "ignored");

    // Vehicle hold: beam high on OPEN cycles 6..8
    step(1'b1, 1'b0);
    repeat (4) step(1'b0, 1'b0);
    chk("hold_enter_open", int'(gate_state), 2);
    open_n = int'(gate_open);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0);
      open_n += int'(gate_open);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1);
      open_n += int'(gate_open);
    end
    chk("hold_count_before_fall", int'(pass_count), 0);
    step(1'b0, 1'b0);
    open_n += int'(gate_open);
    chk("hold_count_after_fall", int'(pass_count), 1);
    k = 0;
    while (gate_open == 1'b1 && k < 50) begin
      step(1'b0, 1'b0);
      k++;
      open_n += int'(gate_open);
    end
    chk("hold_open_len", open_n, 16);
    run_len("hold_close_len", 2'd3, 4);
    chk("hold_closed", int'(gate_state), 0);

    // Reopen on second CLOSING cycle
    step(1'b1, 1'b0);
    run_len("reopen_up1_len", 2'd1, 4);
    run_len("reopen_open1_len", 2'd2, 8);
    chk("reopen_closing1", int'(gate_state), 3);
    step(1'b0, 1'b0);
    chk("reopen_closing2", int'(gate_state), 3);
    step(1'b1, 1'b0);
    chk("reopen_state", int'(gate_state), 1);
    chk("reopen_up", int'(gate_up), 1);
    run_len("reopen_up2_len", 2'd1, 4);
    run_len("reopen_open2_len", 2'd2, 8);
    run_len("reopen_close_len", 2'd3, 4);
    chk("reopen_closed", int'(gate_state), 0);
    chk("reopen_count", int'(pass_count), 1);

    // Asynchronous reset during OPENING
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("midrst_pre_state", int'(gate_state), 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_state", int'(gate_state), 0);
    chk("midrst_up", int'(gate_up), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_count", int'(pass_count), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("midrst_hold_state", int'(gate_state), 0);
    rst = 1'b0;

    // Counter wrap: 255 passes, one more wraps to 0
    step(1'b1, 1'b0);
    run_len("wrap_up_len", 2'd1, 4);
    for (int i = 0; i < 255; i++) begin
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
    end
    chk("wrap_255", int'(pass_count), 255);
    chk("wrap_still_open", int'(gate_state), 2);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    chk("wrap_zero", int'(pass_count), 0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    chk("wrap_one", int'(pass_count), 1);
    k = 0;
    while (gate_state != 2'd0 && k < 100) begin
      step(1'b0, 1'b0);
      k++;
    end
    chk("wrap_closed", int'(gate_state), 0);

    // Falling edge while CLOSED is not counted
    step(1'b0, 1'b1);
    chk("closed_beam_state", int'(gate_state), 0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("closed_fall_count", int'(pass_count), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
